// File: rtl/qs_pkg.sv
// Shared definitions for the quick-sort memory datapath.
// Holds default widths/thresholds and the basic data word type used by
// qs_mem_datapath and qs_delay_counter.
package qs_pkg;

  localparam int WORD_SIZE_DEF   = 16;
  localparam int CNT_W_DEF       = 5;
  localparam int DONE_THRESH_DEF = 3;

  typedef logic [WORD_SIZE_DEF-1:0] word_t;

endpackage

// File: rtl/qs_delay_counter.sv
// Free-running saturating delay counter used by the sort controllers to
// time multi-cycle operations.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset (count -> 0)
//   cnt_clear - synchronous clear (count -> 0)
//   count     - current count, saturates at all-ones
//   cnt_done  - combinational, high when count > DONE_THRESH
module qs_delay_counter
  import qs_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DONE_THRESH = DONE_THRESH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] count,
  output logic             cnt_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(DONE_THRESH);

  // Holds at CNT_MAX so a long wait never wraps back under the threshold.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + CNT_W'(1);
    end
  end

  assign cnt_done = (count > THRESH);

endmodule

// File: rtl/qs_mem_datapath.sv
// Shared memory datapath for the quick-sort engine: a word-addressed
// register-file memory with a registered read port, a 2:1 request mux
// (port A = sort controller, port B = swap unit) and a delay counter.
// Optional build macro: QS_MEM_CLEAR_ON_RESET_EN -- when defined, reset
// also zeroes every memory word; otherwise memory survives reset.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   sel                      - 0 selects port A, 1 selects port B
//   a_read_en/a_write_en/a_addr/a_data_in - port A request
//   b_read_en/b_write_en/b_addr/b_data_in - port B request
//   rd_data                  - registered read data (one-cycle latency)
//   cnt_clear                - delay counter clear
//   count, cnt_done          - delay counter value and threshold flag
module qs_mem_datapath
  import qs_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int DEPTH       = 64,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DONE_THRESH = DONE_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 a_read_en,
  input  logic                 a_write_en,
  input  logic [WORD_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_data_in,
  input  logic                 b_read_en,
  input  logic                 b_write_en,
  input  logic [WORD_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_data_in,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     count,
  output logic                 cnt_done
);

  localparam int                   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(DEPTH);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic                 rd_en;
  logic                 wr_en;
  logic [WORD_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 in_range;
  logic [AW-1:0]        idx;

  // Request mux: the unselected port is ignored entirely.
  assign rd_en   = sel ? b_read_en  : a_read_en;
  assign wr_en   = sel ? b_write_en : a_write_en;
  assign addr    = sel ? b_addr     : a_addr;
  assign wr_data = sel ? b_data_in  : a_data_in;

  // Upper address bits are only used for the range test, so out-of-range
  // addresses never alias onto a low word.
  assign in_range = (addr < DEPTH_W);
  assign idx      = addr[AW-1:0];

  // Memory array; reset blocks writes so it cannot corrupt stored words.
  always_ff @(posedge clk) begin
`ifdef QS_MEM_CLEAR_ON_RESET_EN
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && in_range) begin
      mem[idx] <= wr_data;
    end
`else
    if (!reset && wr_en && in_range) begin
      mem[idx] <= wr_data;
    end
`endif
  end

  // Registered read port: sampling mem before the write lands gives
  // read-before-write on a same-address access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= in_range ? mem[idx] : '0;
    end
  end

  qs_delay_counter #(
    .CNT_W       (CNT_W),
    .DONE_THRESH (DONE_THRESH)
  ) u_delay_counter (
    .clk       (clk),
    .reset     (reset),
    .cnt_clear (cnt_clear),
    .count     (count),
    .cnt_done  (cnt_done)
  );

endmodule

// File: tb/tb_qs_mem_datapath.sv
// Scoreboard bench for qs_mem_datapath: stimulus pushes the expected
// post-edge value of an output, and a negedge monitor pops and compares.
module tb_qs_mem_datapath;
  import qs_pkg::*;

  localparam int K_RD   = 0;
  localparam int K_CNT  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int    due;
    int    kind;
    word_t val;
    string name;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       sel;
  logic       a_read_en, a_write_en, b_read_en, b_write_en;
  word_t      a_addr, a_data_in, b_addr, b_data_in;
  word_t      rd_data;
  logic       cnt_clear;
  logic [4:0] count;
  logic       cnt_done;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  qs_mem_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .a_read_en  (a_read_en),
    .a_write_en (a_write_en),
    .a_addr     (a_addr),
    .a_data_in  (a_data_in),
    .b_read_en  (b_read_en),
    .b_write_en (b_write_en),
    .b_addr     (b_addr),
    .b_data_in  (b_data_in),
    .rd_data    (rd_data),
    .cnt_clear  (cnt_clear),
    .count      (count),
    .cnt_done   (cnt_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      word_t act;
      e = q.pop_front();
      case (e.kind)
        K_RD:    act = rd_data;
        K_CNT:   act = {11'd0, count};
        default: act = {15'd0, cnt_done};
      endcase
      n_checks++;
      if (e.due != cyc) begin
        n_errors++;
        $display("FAIL %s: expectation for cycle %0d checked late at %0d", e.name, e.due, cyc);
      end else if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  // Expect value of an output just after the next clock edge.
  task automatic expect_next(input int kind, input word_t val, input string name);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sel = 1'b0;
    a_read_en = 1'b0; a_write_en = 1'b0; a_addr = '0; a_data_in = '0;
    b_read_en = 1'b0; b_write_en = 1'b0; b_addr = '0; b_data_in = '0;
  endtask

  task automatic a_write(input word_t ad, input word_t d);
    idle();
    a_write_en = 1'b1; a_addr = ad; a_data_in = d;
    step();
  endtask

  task automatic a_read(input word_t ad, input word_t exp_v, input string name);
    idle();
    a_read_en = 1'b1; a_addr = ad;
    expect_next(K_RD, exp_v, name);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    word_t rst_exp;
    idle();
    cnt_clear = 1'b0;

    // Reset state
    reset = 1'b1;
    expect_next(K_RD, 16'h0000, "reset_rd");
    expect_next(K_CNT, 16'd0, "reset_count");
    expect_next(K_DONE, 16'd0, "reset_done");
    step();
    reset = 1'b0;

    // Preload and basic write/read via port A
    a_write(16'd0, 16'h0F0F);
    a_write(16'd5, 16'h00AB);
    a_read(16'd5, 16'h00AB, "rd_a5");
    idle(); a_addr = 16'd9;
    expect_next(K_RD, 16'h00AB, "hold1");
    step();
    expect_next(K_RD, 16'h00AB, "hold2");
    step();

    // Port switch: port B owns the memory, port A's write is ignored
    idle();
    sel = 1'b1;
    b_write_en = 1'b1; b_addr = 16'd7; b_data_in = 16'h1234;
    a_write_en = 1'b1; a_addr = 16'd7; a_data_in = 16'hFFFF;
    step();
    a_read(16'd7, 16'h1234, "port_switch");
    // Port B read while A is selected must not disturb rd_data
    idle();
    b_read_en = 1'b1; b_addr = 16'd5;
    expect_next(K_RD, 16'h1234, "unsel_b_read");
    step();

    // Same-address read-before-write
    a_write(16'd3, 16'h0011);
    idle();
    a_read_en = 1'b1; a_write_en = 1'b1; a_addr = 16'd3; a_data_in = 16'h0022;
    expect_next(K_RD, 16'h0011, "rbw_old");
    step();
    a_read(16'd3, 16'h0022, "rbw_new");

    // Out of range
    a_write(16'd64, 16'h5555);
    a_read(16'd64, 16'h0000, "oor_read");
    a_read(16'd0, 16'h0F0F, "oor_no_alias");

    // Counter: clear, count up, threshold, saturation
    idle();
    cnt_clear = 1'b1;
    expect_next(K_CNT, 16'd0, "cnt_clear");
    step();
    cnt_clear = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      c = (k > 31) ? 31 : k;
      if (k <= 6 || k >= 30) begin
        expect_next(K_CNT, word_t'(c), "cnt_step");
        expect_next(K_DONE, (c > 3) ? 16'd1 : 16'd0, "cnt_done");
      end
      step();
    end
    cnt_clear = 1'b1;
    expect_next(K_CNT, 16'd0, "cnt_mid_clear");
    step();
    cnt_clear = 1'b0;
    expect_next(K_CNT, 16'd1, "cnt_after_clear");
    step();

    // Reset with rd_data=0x00AB and count=9; write/read during reset ignored
    idle();
    a_read_en = 1'b1; a_addr = 16'd5;
    cnt_clear = 1'b1;
    expect_next(K_RD, 16'h00AB, "pre_reset_rd");
    step();
    idle();
    cnt_clear = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) expect_next(K_CNT, 16'd9, "pre_reset_count");
      step();
    end
    reset = 1'b1;
    a_read_en = 1'b1; a_write_en = 1'b1; a_addr = 16'd5; a_data_in = 16'hDEAD;
    expect_next(K_RD, 16'h0000, "rst_rd");
    expect_next(K_CNT, 16'd0, "rst_count");
    expect_next(K_DONE, 16'd0, "rst_done");
    step();
    reset = 1'b0;
`ifdef QS_MEM_CLEAR_ON_RESET_EN
    rst_exp = 16'h0000;
`else
    rst_exp = 16'h00AB;
`endif
    a_read(16'd5, rst_exp, "mem_after_reset");
    idle();
    step();
    step();

    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
